// File: rtl/spi_arbiter.sv
// Two-port round-robin arbiter in front of a single SPI master.
// A port's request is latched and handed to the master, the master's
// completion (rising m_ready) or a watchdog timeout ends the transfer,
// and the result is reported back to the granted port with a done pulse.
module spi_arbiter #(
  parameter logic [31:0] TIMEOUT = 32'd2000000
) (
  input  logic        clk_in,
  input  logic        rst,
  // requester port 0
  input  logic        req_0,
  input  logic [31:0] mosi_data_0,
  input  logic [5:0]  nbits_0,
  output logic        ack_0,
  output logic        done_0,
  output logic [31:0] miso_data_0,
  output logic        err_0,
  output logic        csn_0,
  // requester port 1
  input  logic        req_1,
  input  logic [31:0] mosi_data_1,
  input  logic [5:0]  nbits_1,
  output logic        ack_1,
  output logic        done_1,
  output logic [31:0] miso_data_1,
  output logic        err_1,
  output logic        csn_1,
  // status
  output logic        busy,
  // SPI master side
  output logic        m_request,
  output logic [31:0] m_mosi_data,
  output logic [5:0]  m_nbits,
  input  logic        m_ready,
  input  logic [31:0] m_miso_data,
  input  logic        m_csn
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        grant;
  logic        last_grant;
  logic        m_ready_q;
  logic [31:0] wd_count;

  logic        any_req;
  logic        winner;
  logic        accept;
  logic        ready_rise;
  logic        wd_expired;

  logic [31:0] miso_store [2];
  logic        err_store  [2];

  assign any_req    = req_0 | req_1;
  // On a tie the port that was not served last wins; otherwise whoever asks.
  assign winner     = (req_0 & req_1) ? ~last_grant : req_1;
  assign accept     = (state == IDLE) && any_req;
  assign ready_rise = m_ready & ~m_ready_q;
  // The current BUSY cycle is included in the count, so the transfer is
  // abandoned after exactly TIMEOUT BUSY cycles.
  assign wd_expired = (TIMEOUT != 32'd0) && (wd_count == TIMEOUT - 32'd1);

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; completion and timeout share the exit to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = BUSY;
      BUSY:    if (ready_rise || wd_expired) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state and the stored grant.
  always_comb begin
    busy      = (state != IDLE);
    m_request = (state == ISSUE);
    ack_0     = (state == ISSUE) && (grant == 1'b0);
    ack_1     = (state == ISSUE) && (grant == 1'b1);
    done_0    = (state == DONE) && (grant == 1'b0);
    done_1    = (state == DONE) && (grant == 1'b1);
    csn_0     = (busy && (grant == 1'b0)) ? m_csn : 1'b1;
    csn_1     = (busy && (grant == 1'b1)) ? m_csn : 1'b1;
  end

  // Latch the winning port's command and remember who was granted.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      grant       <= 1'b0;
      m_mosi_data <= 32'd0;
      m_nbits     <= 6'd0;
    end else if (accept) begin
      grant       <= winner;
      m_mosi_data <= winner ? mosi_data_1 : mosi_data_0;
      m_nbits     <= winner ? nbits_1 : nbits_0;
    end
  end

  // Round-robin history, updated once the transfer has been reported.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (state == DONE) begin
      last_grant <= grant;
    end
  end

  // Delayed copy of m_ready for rising-edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m_ready_q <= 1'b0;
    end else begin
      m_ready_q <= m_ready;
    end
  end

  // Watchdog: cleared when a transfer is issued, counts BUSY cycles.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wd_count <= 32'd0;
    end else if (accept) begin
      wd_count <= 32'd0;
    end else if (state == BUSY) begin
      wd_count <= wd_count + 32'd1;
    end
  end

  // Per-port result registers; a genuine completion wins over a
  // simultaneous timeout, and a timeout keeps the previous read word.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        miso_store[gi] <= 32'd0;
        err_store[gi]  <= 1'b0;
      end else if ((state == BUSY) && (grant == 1'(gi))) begin
        if (ready_rise) begin
          miso_store[gi] <= m_miso_data;
          err_store[gi]  <= 1'b0;
        end else if (wd_expired) begin
          err_store[gi]  <= 1'b1;
        end
      end
    end
  end

  assign miso_data_0 = miso_store[0];
  assign miso_data_1 = miso_store[1];
  assign err_0       = err_store[0];
  assign err_1       = err_store[1];

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: behavioural SPI master with loopback, per-port
// request drivers fed from queues, and per-port scoreboards checked on done.
module tb_spi_arbiter;
  localparam int TMO = 50;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        req_0 = 1'b0, req_1 = 1'b0;
  logic [31:0] mosi_data_0 = '0, mosi_data_1 = '0;
  logic [5:0]  nbits_0 = '0, nbits_1 = '0;
  logic        ack_0, ack_1, done_0, done_1, err_0, err_1, csn_0, csn_1, busy;
  logic [31:0] miso_data_0, miso_data_1;
  logic        m_request;
  logic [31:0] m_mosi_data;
  logic [5:0]  m_nbits;
  logic        m_ready;
  logic [31:0] m_miso_data;
  logic        m_csn;

  spi_arbiter #(.TIMEOUT(32'(TMO))) dut (
    .clk_in(clk_in), .rst(rst),
    .req_0(req_0), .mosi_data_0(mosi_data_0), .nbits_0(nbits_0),
    .ack_0(ack_0), .done_0(done_0), .miso_data_0(miso_data_0), .err_0(err_0), .csn_0(csn_0),
    .req_1(req_1), .mosi_data_1(mosi_data_1), .nbits_1(nbits_1),
    .ack_1(ack_1), .done_1(done_1), .miso_data_1(miso_data_1), .err_1(err_1), .csn_1(csn_1),
    .busy(busy), .m_request(m_request), .m_mosi_data(m_mosi_data), .m_nbits(m_nbits),
    .m_ready(m_ready), .m_miso_data(m_miso_data), .m_csn(m_csn)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural SPI master: accepts on m_request while ready, holds csn low
  // for nbits+1 cycles, then presents the write word back as the read word.
  // While stall is set it never finishes.
  logic        stall = 1'b0;
  int          mcnt;
  logic [31:0] mdata;
  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b1; m_csn <= 1'b1; mcnt <= 0; m_miso_data <= '0; mdata <= '0;
    end else if (m_request && m_ready) begin
      m_ready <= 1'b0; m_csn <= 1'b0; mcnt <= int'(m_nbits) + 1;
      mdata <= m_mosi_data; m_miso_data <= ~m_mosi_data;
    end else if (!m_ready && !stall) begin
      if (mcnt > 1) mcnt <= mcnt - 1;
      else if (mcnt == 1) begin mcnt <= 0; m_csn <= 1'b1; m_miso_data <= mdata; end
      else m_ready <= 1'b1;
    end
  end

  // Driver queues {nbits, data}; scoreboard queues {latency, err, data}.
  logic [37:0] drv0 [$];
  logic [37:0] drv1 [$];
  logic [40:0] sb0 [$];
  logic [40:0] sb1 [$];
  logic        force0 = 1'b0;

  int          acks [2] = '{0, 0};
  int          ack_cyc [2] = '{0, 0};
  int          done_cyc [2] = '{0, 0};
  logic        low_seen [2] = '{1'b0, 1'b0};
  logic [31:0] model_miso [2] = '{32'd0, 32'd0};
  logic [7:0]  order_bits = '0;
  logic [37:0] de;
  logic [40:0] se;
  logic        has;
  int          p;
  logic [31:0] exp_miso;

  // Monitor and request driver, all on the falling edge.
  always @(negedge clk_in) begin
    if (rst) begin
      low_seen[0] = 1'b0; low_seen[1] = 1'b0;
      model_miso[0] = '0; model_miso[1] = '0;
    end else begin
      if (ack_0) begin
        check_eq("ack0_pending", 64'(drv0.size() != 0), 64'd1);
        if (drv0.size() != 0) begin
          de = drv0.pop_front();
          check_eq("ack0_mosi", 64'(m_mosi_data), 64'(de[31:0]));
          check_eq("ack0_nbits", 64'(m_nbits), 64'(de[37:32]));
        end
        acks[0]++; ack_cyc[0] = cyc; low_seen[0] = 1'b0; low_seen[1] = 1'b0;
      end
      if (ack_1) begin
        check_eq("ack1_pending", 64'(drv1.size() != 0), 64'd1);
        if (drv1.size() != 0) begin
          de = drv1.pop_front();
          check_eq("ack1_mosi", 64'(m_mosi_data), 64'(de[31:0]));
          check_eq("ack1_nbits", 64'(m_nbits), 64'(de[37:32]));
        end
        acks[1]++; ack_cyc[1] = cyc; low_seen[0] = 1'b0; low_seen[1] = 1'b0;
      end
      if (!csn_0) low_seen[0] = 1'b1;
      if (!csn_1) low_seen[1] = 1'b1;
      if (done_0 || done_1) begin
        check_eq("done_onehot", 64'(done_0 & done_1), 64'd0);
        p = done_1 ? 1 : 0;
        done_cyc[p] = cyc;
        order_bits = {order_bits[6:0], done_1};
        has = 1'b0;
        if (p == 0) begin
          check_eq("sb0_pending", 64'(sb0.size() != 0), 64'd1);
          if (sb0.size() != 0) begin se = sb0.pop_front(); has = 1'b1; end
        end else begin
          check_eq("sb1_pending", 64'(sb1.size() != 0), 64'd1);
          if (sb1.size() != 0) begin se = sb1.pop_front(); has = 1'b1; end
        end
        if (has) begin
          exp_miso = se[32] ? model_miso[p] : se[31:0];
          check_eq($sformatf("miso_%0d", p), 64'(p ? miso_data_1 : miso_data_0), 64'(exp_miso));
          check_eq($sformatf("err_%0d", p), 64'(p ? err_1 : err_0), 64'(se[32]));
          check_eq($sformatf("latency_%0d", p), 64'(cyc - ack_cyc[p]), 64'(se[40:33]));
          check_eq($sformatf("csn_own_%0d", p), 64'(low_seen[p]), 64'd1);
          check_eq($sformatf("csn_other_%0d", p), 64'(low_seen[1-p]), 64'd0);
          if (!se[32]) model_miso[p] = se[31:0];
        end
      end
    end
    req_0 = (drv0.size() != 0) || force0;
    if (drv0.size() != 0) begin mosi_data_0 = drv0[0][31:0]; nbits_0 = drv0[0][37:32]; end
    req_1 = (drv1.size() != 0);
    if (drv1.size() != 0) begin mosi_data_1 = drv1[0][31:0]; nbits_1 = drv1[0][37:32]; end
  end

  // Queue a request; the expected outcome follows from the master timing:
  // read word valid n+3 cycles after ISSUE, done one cycle later, unless
  // the watchdog fires first (done at ISSUE+TMO+1 with err).
  task automatic send(input int port, input logic [31:0] d, input logic [5:0] n, input bit keep);
    logic err_exp;
    int   lat;
    if (stall || (int'(n) + 3 > TMO)) begin err_exp = 1'b1; lat = TMO + 1; end
    else begin err_exp = 1'b0; lat = int'(n) + 4; end
    if (port == 0) begin
      drv0.push_back({n, d});
      if (keep) sb0.push_back({8'(lat), err_exp, d});
    end else begin
      drv1.push_back({n, d});
      if (keep) sb1.push_back({8'(lat), err_exp, d});
    end
  endtask

  task automatic wait_idle(input string tag, input bit need_ready);
    int k;
    k = 0;
    while ((drv0.size() != 0 || drv1.size() != 0 || sb0.size() != 0 || sb1.size() != 0 ||
            busy || (need_ready && !m_ready)) && k < 2000) begin
      @(posedge clk_in); k++;
    end
    check_eq({tag, "_complete"}, 64'(k < 2000), 64'd1);
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_ack(input int port, input int prev, input string tag);
    int k;
    k = 0;
    while (acks[port] == prev && k < 200) begin @(posedge clk_in); k++; end
    #1;
    check_eq(tag, 64'(k < 200), 64'd1);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ctrl"}, 64'({busy, m_request, ack_0, ack_1, done_0, done_1,
                                 err_0, err_1, csn_0, csn_1}), 64'b00_0000_0011);
    check_eq({tag, "_mdata"}, 64'({m_mosi_data, m_nbits}), 64'd0);
    check_eq({tag, "_miso"}, {miso_data_0, miso_data_1}, 64'd0);
  endtask

  int a;
  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    check_reset("rst_init");
    rst = 1'b0;
    @(posedge clk_in); #1;

    // single port-0 loopback transfer
    send(0, 32'h0000_00A5, 6'd7, 1'b1);
    wait_idle("single", 1'b1);

    // port 1 arrives while port 0 is busy; a short port-0 blip is ignored
    a = acks[0];
    send(0, 32'h1111_2222, 6'd12, 1'b1);
    wait_ack(0, a, "turn_ack0");
    repeat (2) @(posedge clk_in);
    #1;
    send(1, 32'h3333_4444, 6'd5, 1'b1);
    force0 = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    force0 = 1'b0;
    wait_idle("turn", 1'b1);
    check_eq("turnaround", 64'(ack_cyc[1] - done_cyc[0]), 64'd2);

    // completion and timeout in the same cycle, then completion one too late
    send(0, 32'hCAFE_0047, 6'd47, 1'b1);
    wait_idle("tie", 1'b1);
    send(1, 32'hBEEF_0048, 6'd48, 1'b1);
    wait_idle("late", 1'b1);

    // master never completes
    stall = 1'b1;
    send(0, 32'h5A5A_0003, 6'd3, 1'b1);
    wait_idle("stall", 1'b0);

    // reset in the middle of a transfer
    a = acks[1];
    send(1, 32'h7777_8888, 6'd3, 1'b0);
    wait_ack(1, a, "abort_ack1");
    repeat (5) @(posedge clk_in);
    #2;
    check_eq("abort_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_reset("abort_rst");
    @(posedge clk_in);
    #2;
    rst = 1'b0;
    stall = 1'b0;
    send(1, 32'h1234_5678, 6'd9, 1'b1);
    wait_idle("after_rst", 1'b1);

    // both ports held together: strict alternation starting with port 0
    send(0, 32'hA0A0_0000, 6'd3, 1'b1);
    send(1, 32'hB1B1_0001, 6'd4, 1'b1);
    send(0, 32'hA2A2_0002, 6'd5, 1'b1);
    send(1, 32'hB3B3_0003, 6'd6, 1'b1);
    wait_idle("rr", 1'b1);
    check_eq("rr_order", 64'(order_bits[3:0]), 64'b0101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
